// File: rtl/fifo_wr_rr_arbiter.sv
// Round-robin write-port arbiter for the 8-entry sync FIFO: NREQ producers,
// bounded bursts, combinational write strobe, stall counter and sticky error.
module fifo_wr_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int DW    = 8,
  parameter int BURST = 4,
  parameter int CNTW  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               fifo_full,
  input  logic               fifo_wr_err,
  output logic               fifo_we,
  output logic [DW-1:0]      fifo_din,
  output logic [IDW-1:0]     grant_id,
  output logic [CNTW-1:0]    stall_cnt,
  output logic               wr_err_stky
);

  localparam int BCW = (BURST < 2) ? 1 : $clog2(BURST + 1);

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [BCW-1:0]  burst_q, burst_d;
  logic [IDW-1:0]  grant_id_q, grant_id_d;
  logic [CNTW-1:0] stall_q, stall_d;
  logic            err_q, err_d;

  logic [IDW-1:0]  cand;
  logic [IDW-1:0]  winner;
  logic            found;
  logic            use_hold;
  logic            grant_ok;
  logic [IDW-1:0]  grant_idx;

  // Rotating priority scan starting just after the last-granted requester.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cand   = '0;
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(ptr_q) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    use_hold  = (state_q == ST_HOLD) && en && req_valid[ptr_q];
    grant_ok  = !rst && en && !fifo_full && (use_hold || found);
    grant_idx = use_hold ? ptr_q : winner;
    req_ready = '0;
    if (grant_ok) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    fifo_we  = |(req_valid & req_ready);
    fifo_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) fifo_din = req_data[i*DW +: DW];
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    burst_d    = burst_q;
    grant_id_d = grant_id_q;
    if (fifo_we) begin
      if (use_hold) begin
        burst_d = burst_q + BCW'(1);
        state_d = (burst_d == BCW'(BURST)) ? ST_ARB : ST_HOLD;
      end else begin
        ptr_d      = winner;
        grant_id_d = winner;
        burst_d    = BCW'(1);
        state_d    = (BURST > 1) ? ST_HOLD : ST_ARB;
      end
    end else if ((state_q == ST_HOLD) && !use_hold) begin
      state_d = ST_ARB;
    end
  end

  // Stall counter saturates rather than wraps.
  always_comb begin
    stall_d = stall_q;
    if (|req_valid && en && fifo_full && (stall_q != '1)) stall_d = stall_q + CNTW'(1);
    err_d = err_q | fifo_wr_err;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ARB;
      ptr_q      <= IDW'(NREQ - 1);
      burst_q    <= '0;
      grant_id_q <= '0;
      stall_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      burst_q    <= burst_d;
      grant_id_q <= grant_id_d;
      stall_q    <= stall_d;
      err_q      <= err_d;
    end
  end

  assign grant_id    = grant_id_q;
  assign stall_cnt   = stall_q;
  assign wr_err_stky = err_q;

endmodule
